// File: rtl/press_event_arbiter.sv
// press_event_arbiter
//   Sits between the button debouncers and the single shared press consumer.
//   Rising edges on the debounced levels set one pending flag per button.
//   Pending presses are then offered one at a time, in round-robin order,
//   over a valid/ready handshake. The block also keeps a wrapping count of
//   accepted presses and a sticky overrun flag.
//
// Ports
//   CLK             system clock, rising edge
//   i_Reset         synchronous, active-high reset
//   i_Button_State  debounced button levels, 1 = pressed
//   i_Event_Ready   consumer takes the offered event this cycle
//   o_Event_Valid   an event is offered on o_Event_Id
//   o_Event_Id      index of the offered button
//   o_Press_Count   accepted events, wraps modulo 2^COUNT_WIDTH
//   o_Overrun       sticky: a press was lost because its button was still pending
//
// state   | meaning
// S_IDLE  | nothing offered; choose the next pending button
// S_OFFER | o_Event_Id offered and held until accepted
module press_event_arbiter #(
  parameter int NUM_BUTTONS = 4,
  parameter int ID_WIDTH    = 2,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   i_Reset,
  input  logic [NUM_BUTTONS-1:0] i_Button_State,
  input  logic                   i_Event_Ready,
  output logic                   o_Event_Valid,
  output logic [ID_WIDTH-1:0]    o_Event_Id,
  output logic [COUNT_WIDTH-1:0] o_Press_Count,
  output logic                   o_Overrun
);

  typedef enum logic {S_IDLE = 1'b0, S_OFFER = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [NUM_BUTTONS-1:0] prev_q;
  logic [NUM_BUTTONS-1:0] pending_q, pending_d;
  logic [ID_WIDTH-1:0]    ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overrun_q, overrun_d;

  logic [NUM_BUTTONS-1:0] press;
  logic [NUM_BUTTONS-1:0] acc_mask;
  logic                   accept;
  logic [ID_WIDTH-1:0]    sel_id;
  logic                   sel_found;

  assign press  = i_Button_State & ~prev_q;
  assign accept = (state_q == S_OFFER) && i_Event_Ready;

  // A press landing on the acceptance cycle of the same button re-arms the
  // flag instead of counting as an overrun.
  always_comb begin
    acc_mask  = '0;
    if (accept) acc_mask = NUM_BUTTONS'(1) << id_q;
    pending_d = (pending_q & ~acc_mask) | press;
    overrun_d = overrun_q | (|(press & pending_q & ~acc_mask));
  end

  // First pending index at or after the pointer, wrapping. Uses only the
  // registered flags, so presses arriving this cycle are not yet visible.
  always_comb begin
    int idx;
    idx       = 0;
    sel_id    = '0;
    sel_found = 1'b0;
    for (int k = 0; k < NUM_BUTTONS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_BUTTONS) idx = idx - NUM_BUTTONS;
      if (!sel_found && pending_q[idx]) begin
        sel_found = 1'b1;
        sel_id    = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          id_d    = sel_id;
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        if (i_Event_Ready) begin
          state_d = S_IDLE;
          count_d = count_q + COUNT_WIDTH'(1);
          ptr_d   = (id_q == ID_WIDTH'(NUM_BUTTONS - 1)) ? '0 : id_q + ID_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // prev_q follows the inputs even in reset so a held button is not a press.
  always_ff @(posedge CLK) begin
    prev_q <= i_Button_State;
    if (i_Reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      ptr_q     <= '0;
      id_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_Event_Valid = (state_q == S_OFFER);
  assign o_Event_Id    = id_q;
  assign o_Press_Count = count_q;
  assign o_Overrun     = overrun_q;

endmodule

// File: tb/tb_press_event_arbiter.sv
module tb_press_event_arbiter;

  logic       CLK = 1'b0;
  logic       i_Reset;
  logic [3:0] i_Button_State;
  logic       i_Event_Ready;
  logic       o_Event_Valid;
  logic [1:0] o_Event_Id;
  logic [7:0] o_Press_Count;
  logic       o_Overrun;

  int n_tests = 0;
  int n_fail  = 0;

  press_event_arbiter #(.NUM_BUTTONS(4), .ID_WIDTH(2), .COUNT_WIDTH(8)) dut (
    .CLK            (CLK),
    .i_Reset        (i_Reset),
    .i_Button_State (i_Button_State),
    .i_Event_Ready  (i_Event_Ready),
    .o_Event_Valid  (o_Event_Valid),
    .o_Event_Id     (o_Event_Id),
    .o_Press_Count  (o_Press_Count),
    .o_Overrun      (o_Overrun)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pending at 1st edge, offered at 2nd, accepted at 3rd (ready held high)
  task automatic press_once(input int b);
    i_Button_State[b] = 1'b1;
    tick();
    i_Button_State[b] = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    i_Reset        = 1'b1;
    i_Button_State = 4'b0100;
    i_Event_Ready  = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(o_Event_Valid), 0);
    check("rst_id", 32'(o_Event_Id), 0);
    check("rst_count", 32'(o_Press_Count), 0);
    check("rst_overrun", 32'(o_Overrun), 0);

    // button 2 held through reset must not produce a press
    i_Reset = 1'b0;
    tick(); tick(); tick();
    check("held_valid", 32'(o_Event_Valid), 0);
    check("held_count", 32'(o_Press_Count), 0);
    i_Button_State = 4'b0000;
    tick();

    // single press on button 1: latency
    i_Button_State = 4'b0010;
    tick();
    check("single_t_valid", 32'(o_Event_Valid), 0);
    tick();
    check("single_t1_valid", 32'(o_Event_Valid), 1);
    check("single_t1_id", 32'(o_Event_Id), 1);
    tick();
    check("single_t2_count", 32'(o_Press_Count), 1);
    check("single_t2_valid", 32'(o_Event_Valid), 0);
    i_Button_State = 4'b0000;
    tick();

    // reset so the pointer starts at 0, then buttons 0,1,3 together
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    i_Button_State = 4'b1011;
    tick();
    check("multi_t0_valid", 32'(o_Event_Valid), 0);
    tick();
    check("multi_ev0_valid", 32'(o_Event_Valid), 1);
    check("multi_ev0_id", 32'(o_Event_Id), 0);
    tick();
    check("multi_gap0_valid", 32'(o_Event_Valid), 0);
    tick();
    check("multi_ev1_valid", 32'(o_Event_Valid), 1);
    check("multi_ev1_id", 32'(o_Event_Id), 1);
    tick();
    check("multi_gap1_valid", 32'(o_Event_Valid), 0);
    tick();
    check("multi_ev2_valid", 32'(o_Event_Valid), 1);
    check("multi_ev2_id", 32'(o_Event_Id), 3);
    tick();
    check("multi_end_valid", 32'(o_Event_Valid), 0);
    check("multi_count", 32'(o_Press_Count), 3);
    i_Button_State = 4'b0000;
    tick();

    // pointer is 0: buttons 3 and 0 together -> 0 first
    i_Button_State = 4'b1001;
    tick(); tick();
    check("ptr_wrap_id", 32'(o_Event_Id), 0);
    tick(); tick();
    check("ptr_wrap_id2", 32'(o_Event_Id), 3);
    tick();
    check("ptr_wrap_count", 32'(o_Press_Count), 5);
    i_Button_State = 4'b0000;
    tick();

    // hold offer of id 2 while button 0 presses (ptr now 0)
    i_Event_Ready  = 1'b0;
    i_Button_State = 4'b0100;
    tick(); tick();
    check("hold_start_valid", 32'(o_Event_Valid), 1);
    check("hold_start_id", 32'(o_Event_Id), 2);
    i_Button_State = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("hold_valid_%0d", k), 32'(o_Event_Valid), 1);
      check($sformatf("hold_id_%0d", k), 32'(o_Event_Id), 2);
    end
    i_Event_Ready = 1'b1;
    tick();
    check("hold_acc_count", 32'(o_Press_Count), 6);
    check("hold_acc_valid", 32'(o_Event_Valid), 0);
    tick();
    check("hold_next_valid", 32'(o_Event_Valid), 1);
    check("hold_next_id", 32'(o_Event_Id), 0);
    tick();
    check("hold_next_count", 32'(o_Press_Count), 7);
    i_Button_State = 4'b0000;
    tick();

    // overrun: button 1 pressed twice while pending and not accepted
    i_Event_Ready  = 1'b0;
    i_Button_State = 4'b0010;
    tick();
    i_Button_State = 4'b0000;
    tick();
    check("ovr_pre", 32'(o_Overrun), 0);
    i_Button_State = 4'b0010;
    tick();
    check("ovr_set", 32'(o_Overrun), 1);
    i_Button_State = 4'b0000;
    tick();
    i_Event_Ready = 1'b1;
    tick();
    check("ovr_count", 32'(o_Press_Count), 8);
    tick();
    check("ovr_no_second", 32'(o_Event_Valid), 0);
    tick();
    check("ovr_sticky", 32'(o_Overrun), 1);
    check("ovr_count_final", 32'(o_Press_Count), 8);

    // second press exactly on the acceptance cycle
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    check("ovr_cleared", 32'(o_Overrun), 0);
    i_Event_Ready  = 1'b0;
    i_Button_State = 4'b0010;
    tick();
    i_Button_State = 4'b0000;
    tick();
    check("same_offer_id", 32'(o_Event_Id), 1);
    i_Event_Ready  = 1'b1;
    i_Button_State = 4'b0010;
    tick();
    check("same_acc_count", 32'(o_Press_Count), 1);
    check("same_acc_ovr", 32'(o_Overrun), 0);
    tick();
    check("same_second_valid", 32'(o_Event_Valid), 1);
    check("same_second_id", 32'(o_Event_Id), 1);
    tick();
    check("same_second_count", 32'(o_Press_Count), 2);
    check("same_ovr_final", 32'(o_Overrun), 0);
    i_Button_State = 4'b0000;
    tick();

    // count wrap: 253 presses -> 255, one more -> 0
    for (int k = 0; k < 253; k++) press_once(3);
    check("wrap_255", 32'(o_Press_Count), 255);
    press_once(3);
    check("wrap_0", 32'(o_Press_Count), 0);
    press_once(2);
    check("wrap_1", 32'(o_Press_Count), 1);

    // reset during OFFER discards the event
    i_Event_Ready  = 1'b0;
    i_Button_State = 4'b0001;
    tick();
    i_Button_State = 4'b0000;
    tick();
    check("rstoffer_valid_pre", 32'(o_Event_Valid), 1);
    i_Reset = 1'b1;
    tick();
    check("rstoffer_valid", 32'(o_Event_Valid), 0);
    check("rstoffer_count", 32'(o_Press_Count), 0);
    i_Reset       = 1'b0;
    i_Event_Ready = 1'b1;
    tick(); tick();
    check("rstoffer_idle", 32'(o_Event_Valid), 0);
    check("rstoffer_count2", 32'(o_Press_Count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/press_event_arbiter.md
Name: press_event_arbiter

Overview:
Arbitration and sequencing stage between a bank of button debouncers and the single shared press-counter/consumer path. It takes NUM_BUTTONS debounced button levels, detects press (rising) edges, and queues one pending flag per button. It then grants pending presses one at a time in round-robin order over a valid/ready handshake. It keeps a wrapping total of accepted presses and a sticky overrun flag for presses lost while one from the same button was still pending.

Parameters:
NUM_BUTTONS, 4, number of debounced button inputs (2..16)
ID_WIDTH, 2, width of o_Event_Id; must satisfy 2^ID_WIDTH >= NUM_BUTTONS
COUNT_WIDTH, 8, width of o_Press_Count

Ports:
CLK  input  1  system clock; all logic on rising edge
i_Reset  input  1  synchronous, active-high reset
i_Button_State  input  NUM_BUTTONS  debounced button levels (1 = pressed), one per button, synchronous to CLK
i_Event_Ready  input  1  consumer accepts the offered event this cycle
o_Event_Valid  output  1  an event is offered on o_Event_Id
o_Event_Id  output  ID_WIDTH  index of the button whose press is offered
o_Press_Count  output  COUNT_WIDTH  total accepted events, wraps modulo 2^COUNT_WIDTH
o_Overrun  output  1  sticky: a press was dropped because that button already had a pending press

Behaviour:
- Clock/reset: single clock CLK; reset is synchronous and active-high on i_Reset. All state changes occur only on the rising edge of CLK.
- Reset values:
  - o_Event_Valid=0, o_Event_Id=0, o_Press_Count=0, o_Overrun=0.
  - Pending flags all 0; round-robin pointer=0; FSM=IDLE.
  - Previous-level register loads i_Button_State, so a button held through reset produces no press.
- Edge detect: press[i] = i_Button_State[i] & ~prev[i]; prev <= i_Button_State every non-reset cycle.
- Pending flags, per button:
  - press[i] sets pending[i].
  - Acceptance of button i (valid & ready & id==i) clears pending[i].
  - press[i] in the same cycle as acceptance of i: pending[i] stays 1 (new press queued); no overrun.
  - press[i] while pending[i]=1 and not being accepted: press is dropped and o_Overrun <= 1. o_Overrun is cleared only by reset.
- FSM, two states:
  - IDLE: o_Event_Valid=0. If any pending bit is 1, select the first pending index at or after the pointer, wrapping past NUM_BUTTONS-1 to 0. Register it into o_Event_Id, set o_Event_Valid=1, go to OFFER. Pending bits set in this same cycle are not visible to the selection.
  - OFFER: o_Event_Valid=1. o_Event_Id is held stable until acceptance; a later-arriving higher-priority press does not preempt it.
  - OFFER, on i_Event_Ready=1: clear pending[id]; o_Press_Count <= o_Press_Count+1 (wrapping 2^COUNT_WIDTH-1 -> 0); pointer <= (id+1) mod NUM_BUTTONS; o_Event_Valid <= 0; go to IDLE.
  - Throughput: at most one event per 2 cycles.
- Latency:
  - Input first sampled high at edge t -> pending set at t.
  - o_Event_Valid high after edge t+1, when IDLE and no other button is selected first.
  - i_Event_Ready held high -> accepted at edge t+2.
- Reset mid-operation: an offered event is discarded without counting; o_Event_Valid is 0 after the reset edge.
- i_Event_Ready is ignored while o_Event_Valid=0.

Test Plan:
- Reset with button 2 held high, then release i_Reset, ready=1 -> no event; o_Press_Count=0.
- Single press on button 1 at edge t, ready=1 -> o_Event_Valid=1 with id=1 after edge t+1; o_Press_Count=1 after edge t+2; o_Event_Valid returns to 0.
- Buttons 0, 1, 3 rise in the same cycle, ready=1 -> events in order id 0, 1, 3, each valid for one cycle with one idle cycle between; o_Press_Count=3; pointer ends at 0.
- Offer id=2 with ready=0 for 5 cycles while button 0 presses -> id stays 2 and valid stays 1 throughout. Then ready=1 -> id=2 accepted, then id=0 offered.
- Button 1 pressed twice, ready=0, releasing between presses -> o_Overrun=1; only one id=1 event is delivered after ready=1. Second press arriving exactly on the acceptance cycle -> two events delivered, o_Overrun=0.
- 256 accepted presses with COUNT_WIDTH=8 -> o_Press_Count wraps 255 -> 0. Assert i_Reset during OFFER -> valid=0 and count=0 after the next edge.
